add_seq: RTL and testbench
==========================

# add_seq

Parametrised multi-cycle adder: a WIDTH-bit addition performed CHUNK bits per clock, with the carry held in a register between chunks. It is the sequential successor to the single-bit full adder and trades latency for a short carry chain. Operands enter through a valid/ready input port, and results leave through a valid/ready output port. It sits between an operand source and a result consumer in the datapath.

## Interface
- WIDTH, 32, operand and result width; must be a multiple of CHUNK.
- CHUNK, 8, bits added per cycle; NCHUNK = WIDTH/CHUNK.
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operands presented.
- in_ready  out  1  block can accept operands.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- cin  in  1  carry-in.
- sub  in  1  subtract select; present only with ADD_SUB_EN.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts the result.
- sum  out  WIDTH  result.
- cout  out  1  carry out of the MSB.
- ovf  out  1  two's-complement overflow.

## Operation
- FSM states:
  - IDLE: in_ready=1. If in_valid, latch a, b_eff and carry=cin_eff, set idx=0, go to RUN.
  - RUN: sum[idx*CHUNK +: CHUNK] = a_chunk + b_eff_chunk + carry; the chunk's carry-out goes to the carry register. idx++. After the chunk with idx = NCHUNK-1, go to DONE.
  - DONE: out_valid=1. If out_ready, go to IDLE.
- Without the macro: b_eff=b, cin_eff=cin.
- cout = final carry.
- ovf = (a[MSB] == b_eff[MSB]) && (sum[MSB] != a[MSB]).
- sum, cout and ovf are stable from DONE entry until the next acceptance.
- in_ready is 0 in RUN and DONE, so there is no overlap between operations.
- Arithmetic is modulo 2^WIDTH.
- The chunk counter is $clog2(NCHUNK) bits wide, with a minimum of 1.
- WIDTH % CHUNK != 0 is an elaboration error.
- CHUNK == WIDTH is legal: RUN lasts 1 cycle.

## Timing
- Reset values:
  - state=IDLE, in_ready=1, out_valid=0.
  - sum=0, cout=0, ovf=0.
  - idx=0, carry=0.
- rst during RUN or DONE aborts the operation on the next edge. The result is discarded and no out_valid pulse occurs.
- Latency: operands accepted at edge E. Chunk k is written at edge E+k+1. DONE and out_valid=1 follow edge E+NCHUNK.
- Throughput: one operation per NCHUNK+2 cycles when out_ready is held high.
- out_valid stays high while out_ready=0, for any duration.
- in_valid while in_ready=0 is ignored. The source must hold its operands until acceptance.
- Operands presented on the same edge that DONE exits to IDLE are not accepted until the following cycle.

## Configuration
- ADD_SUB_EN defined:
  - The sub port exists.
  - With sub=1: b_eff=~b and cin_eff=1, so the block computes a-b. cin is ignored and cout=1 means no borrow.
  - sub is latched at acceptance.
- ADD_SUB_EN undefined: the sub port is absent and the block only adds.

## Structure
- Package add_pkg contains:
  - typedef enum for the FSM states (IDLE, RUN, DONE).
  - Function computing the counter width from WIDTH/CHUNK.
- Sub-module add_chunk: a combinational CHUNK-bit ripple adder with ports a, b, cin, s, cout. It is built from the existing 1-bit full adder and instantiated once.

## Test plan
Defaults WIDTH=32, CHUNK=8.
- a=0x000000FF, b=0x00000001, cin=0 -> sum=0x00000100, cout=0, ovf=0; out_valid 4 edges after the accepting edge.
- a=0xFFFFFFFF, b=0x00000001, cin=0 -> sum=0x00000000, cout=1, ovf=0. Checks carry propagation through all 4 chunks.
- a=0x7FFFFFFF, b=0x00000001, cin=0 -> sum=0x80000000, cout=0, ovf=1.
- ADD_SUB_EN, sub=1, a=5, b=7 -> sum=0xFFFFFFFE, cout=0, ovf=0. Then a=7, b=5 -> sum=0x00000002, cout=1.
- out_ready held low 10 cycles after DONE -> out_valid=1 throughout, sum unchanged, in_ready=0 while in_valid=1. When out_ready rises, the result is consumed and the next operands are accepted 1 cycle later.
- rst pulsed for 1 cycle while idx=2 -> next cycle: state IDLE, in_ready=1, out_valid=0, sum=0. No result appears, and a fresh operation completes correctly.

Source files
------------

// File: rtl/add_pkg.sv
// Shared types and helpers for the chunked sequential adder.
package add_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Chunk counter width: enough bits to index every chunk, never less than one.
    function automatic int cnt_width(input int nchunk);
        return (nchunk > 1) ? $clog2(nchunk) : 1;
    endfunction

endpackage

// File: rtl/add_chunk.sv
// Combinational CHUNK-bit ripple-carry adder made of 1-bit full adders.
module add_chunk #(
    parameter int CHUNK = 8
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] s,
    output logic             cout
);

    // carry[i] feeds bit i; carry[CHUNK] leaves the chunk
    logic [CHUNK:0] carry;

    assign carry[0] = cin;
    assign cout     = carry[CHUNK];

    generate
        for (genvar gi = 0; gi < CHUNK; gi++) begin : g_bit
            full_adder u_fa (
                .a    (a[gi]),
                .b    (b[gi]),
                .cin  (carry[gi]),
                .s    (s[gi]),
                .cout (carry[gi+1])
            );
        end
    endgenerate

endmodule

// File: rtl/full_adder.sv
// 1-bit full adder, the building block of the chunk ripple adder.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/add_seq.sv
// Multi-cycle WIDTH-bit adder: one CHUNK-bit slice per clock with the carry
// held in a register between slices. Valid/ready on both operand and result
// sides; operations never overlap.
// Optional feature: define ADD_SUB_EN to add the sub port (a - b when sub=1).
module add_seq
    import add_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef ADD_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int CW     = cnt_width(NCHUNK);
    localparam logic [CW-1:0] LAST_IDX = CW'(NCHUNK - 1);

    generate
        if (WIDTH % CHUNK != 0) begin : g_bad_width
            $error("add_seq: WIDTH must be a multiple of CHUNK");
        end
    endgenerate

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;       // holds b_eff (already inverted for subtract)
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [CW-1:0]    idx_q, idx_d;
    logic             carry_q, carry_d;
    logic             ovf_q, ovf_d;

    logic [WIDTH-1:0] b_eff;
    logic             cin_eff;
    logic [CHUNK-1:0] chunk_a, chunk_b, chunk_s;
    logic             chunk_co;
    logic             accept;
    logic             last_chunk;

`ifdef ADD_SUB_EN
    assign b_eff   = sub ? ~b : b;
    assign cin_eff = sub ? 1'b1 : cin;
`else
    assign b_eff   = b;
    assign cin_eff = cin;
`endif

    assign chunk_a    = a_q[int'(idx_q) * CHUNK +: CHUNK];
    assign chunk_b    = b_q[int'(idx_q) * CHUNK +: CHUNK];
    assign accept     = in_valid && in_ready;
    assign last_chunk = (idx_q == LAST_IDX);

    add_chunk #(.CHUNK(CHUNK)) u_chunk (
        .a    (chunk_a),
        .b    (chunk_b),
        .cin  (carry_q),
        .s    (chunk_s),
        .cout (chunk_co)
    );

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // FSM next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid) state_d = RUN;
            RUN:     if (last_chunk) state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs: handshake flags decoded from state only
    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
    end

    // Datapath next-state: latch operands on accept, add one slice per RUN cycle
    always_comb begin
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        ovf_d   = ovf_q;
        if (accept) begin
            a_d     = a;
            b_d     = b_eff;
            carry_d = cin_eff;
            idx_d   = '0;
        end else if (state_q == RUN) begin
            sum_d[int'(idx_q) * CHUNK +: CHUNK] = chunk_s;
            carry_d = chunk_co;
            if (last_chunk) begin
                idx_d = '0;
                ovf_d = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (chunk_s[CHUNK-1] != a_q[WIDTH-1]);
            end else begin
                idx_d = idx_q + 1'b1;
            end
        end
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            idx_q   <= '0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            ovf_q   <= ovf_d;
        end
    end

    // The final carry stays in the carry register until the next acceptance.
    assign sum  = sum_q;
    assign cout = carry_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_add_seq.sv
// Directed self-checking bench for add_seq (WIDTH=32, CHUNK=8).
module tb_add_seq;

    localparam int WIDTH = 32;
    localparam int CHUNK = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    add_seq #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
`ifdef ADD_SUB_EN
        .sub       (sub),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Wait for out_valid after the accepting edge; returns edges waited.
    task automatic wait_done(output int n);
        n = 0;
        while (out_valid !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
    endtask

    // Full operation with out_ready held high; checks latency, result, handback.
    task automatic run_op(input string tag, input logic [31:0] oa, input logic [31:0] ob,
                          input logic oc, input logic os,
                          input logic [31:0] es, input logic ec, input logic eo);
        int n;
        a = oa; b = ob; cin = oc; sub = os;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        tick();                          // accepting edge
        in_valid = 1'b0;
        chk({tag, ".in_ready_busy"}, 64'(in_ready), 64'd0);
        wait_done(n);
        chk({tag, ".latency"}, 64'(n), 64'd4);
        chk({tag, ".sum"},  64'(sum),  64'(es));
        chk({tag, ".cout"}, 64'(cout), 64'(ec));
        chk({tag, ".ovf"},  64'(ovf),  64'(eo));
        $display("op %s a=%08h b=%08h cin=%0d sub=%0d -> sum=%08h cout=%0d ovf=%0d",
                 tag, oa, ob, oc, os, sum, cout, ovf);
        tick();                          // result consumed
        chk({tag, ".out_valid_clr"}, 64'(out_valid), 64'd0);
        chk({tag, ".in_ready_back"}, 64'(in_ready), 64'd1);
    endtask

    initial begin
        int n;
        logic [31:0] held;
        rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0; out_ready = 1'b1;
        tick(); tick();
        rst = 1'b0;
        chk("reset.in_ready",  64'(in_ready),  64'd1);
        chk("reset.out_valid", 64'(out_valid), 64'd0);
        chk("reset.sum",       64'(sum),       64'd0);
        chk("reset.cout",      64'(cout),      64'd0);
        chk("reset.ovf",       64'(ovf),       64'd0);
        $display("reset released: in_ready=%0d out_valid=%0d sum=%08h", in_ready, out_valid, sum);

        run_op("chunk_carry", 32'h000000FF, 32'h00000001, 1'b0, 1'b0, 32'h00000100, 1'b0, 1'b0);
        run_op("full_carry",  32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0);
        run_op("pos_ovf",     32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1);
        run_op("neg_ovf",     32'h80000000, 32'h80000000, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b1);
        run_op("cin_in",      32'h12345678, 32'h11111111, 1'b1, 1'b0, 32'h2345678A, 1'b0, 1'b0);
`ifdef ADD_SUB_EN
        run_op("sub_neg",     32'h00000005, 32'h00000007, 1'b0, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0);
        run_op("sub_pos",     32'h00000007, 32'h00000005, 1'b0, 1'b1, 32'h00000002, 1'b1, 1'b0);
`endif

        // Backpressure: hold out_ready low, offer new operands meanwhile.
        a = 32'h00010000; b = 32'h00020000; cin = 1'b0; sub = 1'b0;
        in_valid = 1'b1; out_ready = 1'b0;
        tick();
        a = 32'hDEADBEEF; b = 32'h01010101;   // next operands, must wait
        wait_done(n);
        chk("bp.latency", 64'(n), 64'd4);
        held = 32'h00030000;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("bp.out_valid_hold", 64'(out_valid), 64'd1);
            chk("bp.sum_hold",       64'(sum),       64'(held));
            chk("bp.in_ready_low",   64'(in_ready),  64'd0);
        end
        $display("backpressure held 10 cycles: sum=%08h out_valid=%0d", sum, out_valid);
        out_ready = 1'b1;
        tick();                                  // consume edge; in_valid still high
        chk("bp.consumed",     64'(out_valid), 64'd0);
        chk("bp.not_accepted", 64'(in_ready),  64'd1);
        tick();                                  // accepted one cycle later
        in_valid = 1'b0;
        chk("bp.accepted", 64'(in_ready), 64'd0);
        wait_done(n);
        chk("bp2.latency", 64'(n), 64'd4);
        chk("bp2.sum",  64'(sum),  64'h DFAEBFF0);
        chk("bp2.cout", 64'(cout), 64'd0);
        $display("op after backpressure: sum=%08h cout=%0d ovf=%0d", sum, cout, ovf);
        tick();

        // Reset in the middle of RUN (idx=2): result discarded.
        a = 32'h11111111; b = 32'h22222222; cin = 1'b0;
        in_valid = 1'b1;
        tick();                                  // accepted, idx=0
        in_valid = 1'b0;
        tick(); tick();                          // idx=2
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort.in_ready",  64'(in_ready),  64'd1);
        chk("abort.out_valid", 64'(out_valid), 64'd0);
        chk("abort.sum",       64'(sum),       64'd0);
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("abort.no_result", 64'(out_valid), 64'd0);
        end
        $display("abort by reset: in_ready=%0d out_valid=%0d sum=%08h", in_ready, out_valid, sum);
        run_op("after_abort", 32'h11111111, 32'h22222222, 1'b0, 1'b0, 32'h33333333, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
